// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with grant lock: a granted port keeps the grant while it
// requests, but is preempted after MAX_HOLD cycles if another port is waiting.
// Latency: one cycle from req_i to gnt_o; all outputs registered. No backpressure.
module rr_lock_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int MAX_HOLD  = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_PORTS-1:0]                    req_i,
    output logic [NUM_PORTS-1:0]                    gnt_o,
    output logic                                    gnt_valid_o,
    output logic [(NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1)-1:0] gnt_id_o
);

    localparam int IDW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0]  CNT_MAX  = CW'(MAX_HOLD - 1);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_PORTS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state;
    logic [IDW-1:0]       ptr;
    logic [CW-1:0]        cnt;

    // Candidate search: the current holder is masked out so that release and
    // preemption both pick the next other requester starting from ptr.
    logic [NUM_PORTS-1:0] cand_mask;
    logic                 cand_found;
    logic [IDW-1:0]       cand_id;
    logic [NUM_PORTS-1:0] cand_onehot;
    logic [IDW-1:0]       cand_ptr;
    logic                 holder_req;

    // First set bit of cand_mask in circular order starting at ptr.
    always_comb begin
        cand_mask  = req_i & ~gnt_o;
        cand_found = 1'b0;
        cand_id    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            int idx;
            idx = int'(ptr) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!cand_found && cand_mask[idx]) begin
                cand_found = 1'b1;
                cand_id    = IDW'(idx);
            end
        end
        cand_onehot = '0;
        cand_onehot[cand_id] = 1'b1;
        cand_ptr    = (cand_id == LAST_IDX) ? '0 : cand_id + IDW'(1);
        holder_req  = req_i[gnt_id_o];
    end

    // Grant FSM: registered grant outputs, rotating pointer and hold counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            gnt_o       <= '0;
            gnt_valid_o <= 1'b0;
            gnt_id_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cand_found) begin
                        state       <= HOLD;
                        ptr         <= cand_ptr;
                        cnt         <= '0;
                        gnt_o       <= cand_onehot;
                        gnt_valid_o <= 1'b1;
                        gnt_id_o    <= cand_id;
                    end
                end
                HOLD: begin
                    if (!holder_req || (cnt == CNT_MAX)) begin
                        // Release or hold limit reached: hand over if anyone waits.
                        if (cand_found) begin
                            ptr         <= cand_ptr;
                            cnt         <= '0;
                            gnt_o       <= cand_onehot;
                            gnt_valid_o <= 1'b1;
                            gnt_id_o    <= cand_id;
                        end else if (!holder_req) begin
                            state       <= IDLE;
                            cnt         <= '0;
                            gnt_o       <= '0;
                            gnt_valid_o <= 1'b0;
                            gnt_id_o    <= '0;
                        end
                        // Lone holder at the limit: counter stays saturated.
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state       <= IDLE;
                    gnt_o       <= '0;
                    gnt_valid_o <= 1'b0;
                    gnt_id_o    <= '0;
                end
            endcase
        end
    end

endmodule
